alu_mdu: RTL

Multi-cycle, parametrised successor to the single-cycle execute ALU. It adds the RV32M multiply/divide/remainder operations on top of the full base ALU operation set, and it registers every result behind a valid/ready handshake. The block sits in the execute stage, and the hazard unit stalls upstream stages while `InReady` is low.

---
 rtl/alu_mdu.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with RV32M multiply/divide/remainder.
// Every result is registered and offered through a valid/ready handshake.
//
// Base operations finish in one cycle. MUL* runs a shift-add multiplier
// and DIV*/REM* runs a restoring divider. Both work on operand magnitudes,
// take one bit per cycle, and fix the sign at the end.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   InValid     request present
//   InReady     request can be accepted this cycle
//   SrcA, SrcB  operands
//   PC          instruction PC (AUIPC, JAL)
//   ALUControl  operation select
//   OutValid    ALUResult/Zero hold a result
//   OutReady    consumer takes the result
//   ALUResult   registered result
//   Zero        registered, 1 iff ALUResult == 0
`timescale 1ns/1ps
module alu_mdu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 5,
    parameter int SHIFT_WIDTH    = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [DATA_WIDTH-1:0]     SrcA,
    input  logic [DATA_WIDTH-1:0]     SrcB,
    input  logic [DATA_WIDTH-1:0]     PC,
    input  logic [ALU_CTRL_WIDTH-1:0] ALUControl,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [DATA_WIDTH-1:0]     ALUResult,
    output logic                      Zero
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [ALU_CTRL_WIDTH-1:0] OP_SUB   = ALU_CTRL_WIDTH'(5'h01);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLL   = ALU_CTRL_WIDTH'(5'h02);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLT   = ALU_CTRL_WIDTH'(5'h03);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLTU  = ALU_CTRL_WIDTH'(5'h04);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_XOR   = ALU_CTRL_WIDTH'(5'h05);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_SRL   = ALU_CTRL_WIDTH'(5'h06);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_SRA   = ALU_CTRL_WIDTH'(5'h07);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_OR    = ALU_CTRL_WIDTH'(5'h08);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_AND   = ALU_CTRL_WIDTH'(5'h09);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_AUIPC = ALU_CTRL_WIDTH'(5'h0A);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_LUI   = ALU_CTRL_WIDTH'(5'h0B);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_JAL   = ALU_CTRL_WIDTH'(5'h0C);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_MUL   = ALU_CTRL_WIDTH'(5'h10);
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_REMU  = ALU_CTRL_WIDTH'(5'h17);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [W-1:0]           r_result;
    logic                   r_zero;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*W-1:0]         r_acc;     // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
    logic [W-1:0]           r_mcand;   // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic                   r_neg_q;   // negate product / quotient
    logic                   r_neg_r;   // negate remainder
    logic                   r_sel;     // MUL: take high half; DIV: take remainder

    logic [SHIFT_WIDTH-1:0] w_shamt;
    logic signed [W-1:0]    w_a_s, w_b_s;
    logic [W-1:0]           w_base, w_res, w_spec_res, w_a_mag, w_b_mag;
    logic [W-1:0]           w_mul_res, w_div_res;
    logic [2*W-1:0]         w_step, w_prod, w_first;
    logic [2:0]             w_mop;
    logic                   w_is_m, w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic                   w_special, w_last, w_load, w_start, w_busy;

    // One shift-add step: add multiplicand into the top half when the
    // multiplier LSB is set, then shift the whole accumulator right.
    function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] acc,
                                                input logic [W-1:0]   mcand);
        logic [W:0] sum;
        sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        return {sum, acc[W-1:1]};
    endfunction

    // One restoring-division step; returns {remainder, quotient}.
    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                                input logic [W-1:0] quo,
                                                input logic [W-1:0] dvsr);
        logic [W:0] shl;
        logic       ge;
        shl = {rem, quo[W-1]};
        ge  = (shl >= {1'b0, dvsr});
        return {(ge ? (shl[W-1:0] - dvsr) : shl[W-1:0]), quo[W-2:0], ge};
    endfunction

    function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    assign w_shamt = SrcB[SHIFT_WIDTH-1:0];
    assign w_a_s   = SrcA;
    assign w_b_s   = SrcB;

    always_comb begin
        w_base = SrcA + SrcB;
        case (ALUControl)
            OP_SUB:   w_base = SrcA - SrcB;
            OP_SLL:   w_base = SrcA << w_shamt;
            OP_SLT:   w_base = {{(W-1){1'b0}}, (w_a_s < w_b_s)};
            OP_SLTU:  w_base = {{(W-1){1'b0}}, (SrcA < SrcB)};
            OP_XOR:   w_base = SrcA ^ SrcB;
            OP_SRL:   w_base = SrcA >> w_shamt;
            OP_SRA:   w_base = w_a_s >>> w_shamt;
            OP_OR:    w_base = SrcA | SrcB;
            OP_AND:   w_base = SrcA & SrcB;
            OP_AUIPC: w_base = (SrcB << 12) + PC;
            OP_LUI:   w_base = SrcB << 12;
            OP_JAL:   w_base = PC + W'(4);
            default:  ;
        endcase
    end

    // M-op decode: which operands are treated as signed, and their magnitudes.
    assign w_mop    = ALUControl[2:0];
    assign w_is_m   = (ALUControl >= OP_MUL) && (ALUControl <= OP_REMU);
    assign w_is_div = w_mop[2];
    assign w_a_sgn  = w_is_div ? ~w_mop[0] : (w_mop != 3'd3);
    assign w_b_sgn  = w_is_div ? ~w_mop[0] : (w_mop[2:1] == 2'b00);
    assign w_a_neg  = w_a_sgn & SrcA[W-1];
    assign w_b_neg  = w_b_sgn & SrcB[W-1];
    assign w_a_mag  = neg_if(SrcA, w_a_neg);
    assign w_b_mag  = neg_if(SrcB, w_b_neg);

    // Divide by zero, and signed most-negative / -1, skip the iteration.
    always_comb begin
        logic w_dz;
        logic w_ovf;
        w_dz       = (SrcB == '0);
        w_ovf      = w_a_sgn && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
        w_special  = w_is_div && (w_dz || w_ovf);
        w_spec_res = w_dz ? (w_mop[1] ? SrcA : '1) : (w_mop[1] ? '0 : SrcA);
    end

    // The first iteration runs on the accept edge, so W iterations complete
    // W-1 cycles later and the result is valid in cycle W after accept.
    assign w_first = w_is_div ? div_step({W{1'b0}}, w_a_mag, w_b_mag)
                              : mul_step({{W{1'b0}}, w_b_mag}, w_a_mag);
    assign w_step  = (r_state == S_DIV) ? div_step(r_acc[2*W-1:W], r_acc[W-1:0], r_mcand)
                                        : mul_step(r_acc, r_mcand);
    assign w_prod    = r_neg_q ? (~w_step + 1'b1) : w_step;
    assign w_mul_res = r_sel ? w_prod[2*W-1:W] : w_prod[W-1:0];
    assign w_div_res = r_sel ? neg_if(w_step[2*W-1:W], r_neg_r)
                             : neg_if(w_step[W-1:0], r_neg_q);
    assign w_last    = (r_cnt == CNT_W'(W - 1));
    assign w_busy    = (r_state == S_MUL) || (r_state == S_DIV);

    always_comb begin
        w_state_nxt = r_state;
        InReady     = 1'b0;
        OutValid    = 1'b0;
        w_load      = 1'b0;
        w_start     = 1'b0;
        w_res       = w_base;
        case (r_state)
            S_IDLE: InReady = 1'b1;
            S_DONE: begin
                OutValid = 1'b1;
                InReady  = OutReady;
            end
            S_MUL: if (w_last) begin
                w_state_nxt = S_DONE;
                w_load      = 1'b1;
                w_res       = w_mul_res;
            end
            S_DIV: if (w_last) begin
                w_state_nxt = S_DONE;
                w_load      = 1'b1;
                w_res       = w_div_res;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (InValid && InReady) begin
            if (!w_is_m) begin
                w_state_nxt = S_DONE;
                w_load      = 1'b1;
                w_res       = w_base;
            end else if (w_special) begin
                w_state_nxt = S_DONE;
                w_load      = 1'b1;
                w_res       = w_spec_res;
            end else begin
                w_start     = 1'b1;
                w_state_nxt = w_is_div ? S_DIV : S_MUL;
            end
        end else if ((r_state == S_DONE) && OutReady) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_result <= w_res;
                r_zero   <= (w_res == '0);
            end
            if (w_start)
                r_cnt <= CNT_W'(1);
            else if (w_busy)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Iteration datapath: reset not needed, only read while MUL/DIV is active.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_acc   <= w_first;
            r_mcand <= w_is_div ? w_b_mag : w_a_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_sel   <= w_is_div ? w_mop[1] : (w_mop != 3'd0);
        end else if (w_busy) begin
            r_acc <= w_step;
        end
    end

    assign ALUResult = r_result;
    assign Zero      = r_zero;

endmodule
